ternary_accum_stream: RTL and testbench



---
 rtl/ternary_accum_pkg.sv | 24 ++
 rtl/ternary_add.sv | 34 +++
 rtl/ternary_accum_stream.sv | 196 +++++++++++++++++++
 tb/tb_ternary_accum_stream.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ternary_accum_pkg.sv
// Shared definitions for the ternary accumulator stream.
// Contents: FSM state encoding, clog2 constant function and the
// ACC_WIDTH / CNT_W derivation macros used by ternary_accum_stream.

`define TERNARY_ACCUM_ACC_W(w, n) ((w) + ternary_accum_pkg::clog2(n))
`define TERNARY_ACCUM_CNT_W(n) (ternary_accum_pkg::clog2((n) + 1))

package ternary_accum_pkg;

  typedef enum logic [1:0] {
    EVEN = 2'd0,
    ODD  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Ceiling log2, usable in constant expressions.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (longint unsigned p = 1; p < longint'(v); p = p << 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/ternary_add.sv
// Three-operand adder with two guard bits on the result.
// Params: W operand width; SIGN_EXT 1 = operands are two's complement.
// Ports : a, b, c  W-bit operands
//         sum_c    W+2-bit full-precision sum (combinational)

module ternary_add #(
  parameter int unsigned W        = 8,
  parameter bit          SIGN_EXT = 1'b0
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W+1:0] sum_c
);

  logic [W+1:0] a_x;
  logic [W+1:0] b_x;
  logic [W+1:0] c_x;

  // Extend to the guard width, then one flat add.
  always_comb begin
    if (SIGN_EXT) begin
      a_x = {{2{a[W-1]}}, a};
      b_x = {{2{b[W-1]}}, b};
      c_x = {{2{c[W-1]}}, c};
    end else begin
      a_x = {2'b00, a};
      b_x = {2'b00, b};
      c_x = {2'b00, c};
    end
    sum_c = a_x + b_x + c_x;
  end

endmodule

// File: rtl/ternary_accum_stream.sv
// Streaming packet summer: pairs input words and folds each pair into a
// running accumulator with a single ternary add (acc + pending + din).
// Optional macro TERNARY_ACCUM_OVF_EN adds the sticky ovf output.
// Ports: clk, rst (sync, active-high)
//        din/din_valid/din_last/din_ready  input word stream
//        sum/count/sum_valid/sum_ready     packet result stream
//        ovf                               overflow flag (macro only)

module ternary_accum_stream
  import ternary_accum_pkg::*;
#(
  parameter  int unsigned WIDTH     = 8,
  parameter  int unsigned SIGN_EXT  = 0,
  parameter  int unsigned MAX_WORDS = 256,
  localparam int unsigned ACC_WIDTH = `TERNARY_ACCUM_ACC_W(WIDTH, MAX_WORDS),
  localparam int unsigned CNT_W     = `TERNARY_ACCUM_CNT_W(MAX_WORDS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     din,
  input  logic                 din_valid,
  input  logic                 din_last,
  output logic                 din_ready,
  output logic [ACC_WIDTH-1:0] sum,
  output logic [CNT_W-1:0]     count,
  output logic                 sum_valid,
  input  logic                 sum_ready
`ifdef TERNARY_ACCUM_OVF_EN
  ,
  output logic                 ovf
`endif
);

  localparam int unsigned    EXT_W   = ACC_WIDTH - WIDTH;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WORDS);

  state_e                state_q, state_d;
  logic [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic [WIDTH-1:0]      pending_q, pending_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ACC_WIDTH-1:0]  sum_q, sum_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  sum_valid_q, sum_valid_d;

  logic                  accept;
  logic                  cnt_full;
  logic [ACC_WIDTH-1:0]  op_b;
  logic [ACC_WIDTH-1:0]  op_c;
  logic [ACC_WIDTH+1:0]  add_y;

  function automatic logic [ACC_WIDTH-1:0] extend(input logic [WIDTH-1:0] x);
    if (SIGN_EXT != 0) return {{EXT_W{x[WIDTH-1]}}, x};
    return {{EXT_W{1'b0}}, x};
  endfunction

  // Ready drops combinationally during reset so nothing is taken that cycle.
  assign din_ready = !rst && (state_q != DONE);
  assign accept    = din_valid & din_ready;
  assign cnt_full  = (cnt_q == CNT_MAX);

  // Pending word joins the add only when one is held (ODD).
  assign op_b = (state_q == ODD) ? extend(pending_q) : '0;
  assign op_c = extend(din);

  // Operands are already extended, so the adder runs unsigned.
  ternary_add #(
    .W        (ACC_WIDTH),
    .SIGN_EXT (1'b0)
  ) u_add (
    .a     (acc_q),
    .b     (op_b),
    .c     (op_c),
    .sum_c (add_y)
  );

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    pending_d   = pending_q;
    cnt_d       = cnt_q;
    sum_d       = sum_q;
    count_d     = count_q;
    sum_valid_d = sum_valid_q;
    case (state_q)
      EVEN, ODD: begin
        if (accept) begin
          cnt_d = cnt_full ? cnt_q : cnt_q + CNT_W'(1);
          if (din_last) begin
            sum_d       = add_y[ACC_WIDTH-1:0];
            count_d     = cnt_d;
            sum_valid_d = 1'b1;
            state_d     = DONE;
          end else if (state_q == EVEN) begin
            pending_d = din;
            state_d   = ODD;
          end else begin
            acc_d   = add_y[ACC_WIDTH-1:0];
            state_d = EVEN;
          end
        end
      end
      DONE: begin
        if (sum_ready) begin
          sum_valid_d = 1'b0;
          acc_d       = '0;
          pending_d   = '0;
          cnt_d       = '0;
          state_d     = EVEN;
        end
      end
      default: state_d = EVEN;
    endcase
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EVEN;
      acc_q       <= '0;
      pending_q   <= '0;
      cnt_q       <= '0;
      sum_q       <= '0;
      count_q     <= '0;
      sum_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      pending_q   <= pending_d;
      cnt_q       <= cnt_d;
      sum_q       <= sum_d;
      count_q     <= count_d;
      sum_valid_q <= sum_valid_d;
    end
  end

  assign sum       = sum_q;
  assign count     = count_q;
  assign sum_valid = sum_valid_q;

`ifdef TERNARY_ACCUM_OVF_EN
  logic       ovf_run_q, ovf_run_d;
  logic       ovf_q, ovf_d;
  logic       add_ovf;
  logic       pkt_ovf;
  logic [1:0] neg_cnt;
  logic [1:0] top_adj;

  // Add overflow from the guard bits. Signed: remove the sign-bit weight the
  // zero-extending adder added, then the top three bits must agree.
  always_comb begin
    neg_cnt = 2'(acc_q[ACC_WIDTH-1]) + 2'(op_b[ACC_WIDTH-1]) + 2'(op_c[ACC_WIDTH-1]);
    top_adj = add_y[ACC_WIDTH+1:ACC_WIDTH] - neg_cnt;
    if (SIGN_EXT != 0) begin
      add_ovf = !(({top_adj, add_y[ACC_WIDTH-1]} == 3'b000) ||
                  ({top_adj, add_y[ACC_WIDTH-1]} == 3'b111));
    end else begin
      add_ovf = |add_y[ACC_WIDTH+1:ACC_WIDTH];
    end
  end

  // Overflow is gathered across the packet and published with the sum.
  always_comb begin
    ovf_run_d = ovf_run_q;
    ovf_d     = ovf_q;
    pkt_ovf   = 1'b0;
    if (state_q == DONE) begin
      if (sum_ready) begin
        ovf_run_d = 1'b0;
        ovf_d     = 1'b0;
      end
    end else if (accept) begin
      // EVEN non-last only parks the word; no add is committed there.
      pkt_ovf   = ovf_run_q | cnt_full | (((state_q == ODD) || din_last) & add_ovf);
      ovf_run_d = pkt_ovf;
      if (din_last) ovf_d = pkt_ovf;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_run_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      ovf_run_q <= ovf_run_d;
      ovf_q     <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`else
  logic [1:0] unused_carry;
  assign unused_carry = add_y[ACC_WIDTH+1:ACC_WIDTH];
`endif

endmodule

// File: tb/tb_ternary_accum_stream.sv
// Bench for ternary_accum_stream: three instances (unsigned default,
// signed, MAX_WORDS=4) share one stimulus path selected by sel.

module tb_ternary_accum_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] din;
  logic       din_valid;
  logic       din_last;
  logic       sum_ready;
  int         sel;

  logic        rdy0, rdy1, rdy2;
  logic [15:0] s0, s1;
  logic [9:0]  s2;
  logic [8:0]  c0, c1;
  logic [2:0]  c2;
  logic        v0, v1, v2;
`ifdef TERNARY_ACCUM_OVF_EN
  logic        o0, o1, o2;
`endif

  ternary_accum_stream #(.WIDTH(8), .SIGN_EXT(0), .MAX_WORDS(256)) u0 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid && sel == 0),
    .din_last(din_last), .din_ready(rdy0), .sum(s0), .count(c0),
    .sum_valid(v0), .sum_ready(sum_ready && sel == 0)
`ifdef TERNARY_ACCUM_OVF_EN
    , .ovf(o0)
`endif
  );

  ternary_accum_stream #(.WIDTH(8), .SIGN_EXT(1), .MAX_WORDS(256)) u1 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid && sel == 1),
    .din_last(din_last), .din_ready(rdy1), .sum(s1), .count(c1),
    .sum_valid(v1), .sum_ready(sum_ready && sel == 1)
`ifdef TERNARY_ACCUM_OVF_EN
    , .ovf(o1)
`endif
  );

  ternary_accum_stream #(.WIDTH(8), .SIGN_EXT(0), .MAX_WORDS(4)) u2 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid && sel == 2),
    .din_last(din_last), .din_ready(rdy2), .sum(s2), .count(c2),
    .sum_valid(v2), .sum_ready(sum_ready && sel == 2)
`ifdef TERNARY_ACCUM_OVF_EN
    , .ovf(o2)
`endif
  );

  logic        obs_rdy, obs_valid, obs_ovf;
  logic [15:0] obs_sum;
  logic [8:0]  obs_cnt;

  always_comb begin
    obs_ovf = 1'b0;
    case (sel)
      1: begin obs_rdy = rdy1; obs_valid = v1; obs_sum = s1; obs_cnt = c1; end
      2: begin obs_rdy = rdy2; obs_valid = v2; obs_sum = 16'(s2); obs_cnt = 9'(c2); end
      default: begin obs_rdy = rdy0; obs_valid = v0; obs_sum = s0; obs_cnt = c0; end
    endcase
`ifdef TERNARY_ACCUM_OVF_EN
    obs_ovf = (sel == 1) ? o1 : (sel == 2) ? o2 : o0;
`endif
  end

  typedef struct {
    logic [15:0] sum;
    logic [8:0]  cnt;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] s, input logic [8:0] c, input logic o);
    exp_t e;
    e.sum = s;
    e.cnt = c;
    e.ovf = o;
    sb.push_back(e);
  endtask

  // One word, accepted on the next edge.
  task automatic send(input logic [7:0] w, input logic last);
    din       = w;
    din_valid = 1'b1;
    din_last  = last;
    check("din_ready_before_word", 32'(obs_rdy), 32'd1);
    if (last) check("valid_low_before_last", 32'(obs_valid), 32'd0);
    tick();
    din_valid = 1'b0;
    din_last  = 1'b0;
    din       = 8'h00;
  endtask

  // Wait (bounded) for a result and compare it with the scoreboard head.
  task automatic collect();
    exp_t e;
    int   n;
    n = 0;
    while (!obs_valid && n < 4) begin
      tick();
      n++;
    end
    check("result_latency", 32'(n), 32'd0);
    check("sum_valid_high", 32'(obs_valid), 32'd1);
    check("din_ready_low_in_done", 32'(obs_rdy), 32'd0);
    if (sb.size() == 0) begin
      check("scoreboard_nonempty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check("sum", 32'(obs_sum), 32'(e.sum));
      check("count", 32'(obs_cnt), 32'(e.cnt));
`ifdef TERNARY_ACCUM_OVF_EN
      check("ovf", 32'(obs_ovf), 32'(e.ovf));
`endif
    end
  endtask

  task automatic handshake();
    sum_ready = 1'b1;
    tick();
    sum_ready = 1'b0;
    check("valid_cleared", 32'(obs_valid), 32'd0);
    check("ready_after_handshake", 32'(obs_rdy), 32'd1);
`ifdef TERNARY_ACCUM_OVF_EN
    check("ovf_cleared", 32'(obs_ovf), 32'd0);
`endif
  endtask

  initial begin
    rst       = 1'b1;
    din       = 8'h00;
    din_valid = 1'b0;
    din_last  = 1'b0;
    sum_ready = 1'b0;
    sel       = 0;

    // Reset state
    tick();
    check("rst_sum", 32'(obs_sum), 32'd0);
    check("rst_count", 32'(obs_cnt), 32'd0);
    check("rst_valid", 32'(obs_valid), 32'd0);
    check("rst_ready", 32'(obs_rdy), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    check("ready_after_rst", 32'(obs_rdy), 32'd1);

    // Odd-length packet, back-to-back words
    push(16'd60, 9'd3, 1'b0);
    send(8'd10, 1'b0);
    send(8'd20, 1'b0);
    send(8'd30, 1'b1);
    collect();
    handshake();

    // Single word: EVEN last path
    push(16'd255, 9'd1, 1'b0);
    send(8'hFF, 1'b1);
    collect();
    handshake();

    // Two words: ODD last path
    push(16'd3, 9'd2, 1'b0);
    send(8'd1, 1'b0);
    send(8'd2, 1'b1);
    collect();
    handshake();

    // Valid gap between words: pending must hold
    push(16'd11, 9'd2, 1'b0);
    send(8'd5, 1'b0);
    din = 8'hAA;
    repeat (3) tick();
    send(8'd6, 1'b1);
    collect();
    handshake();

    // Five words: ODD non-last folds then EVEN last
    push(16'd15, 9'd5, 1'b0);
    for (int i = 1; i <= 5; i++) send(8'(i), i == 5);
    collect();
    handshake();

    // Backpressure: result held while din_valid stays high
    push(16'd8, 9'd2, 1'b0);
    send(8'd3, 1'b0);
    send(8'd5, 1'b1);
    collect();
    din       = 8'h77;
    din_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_ready_low", 32'(obs_rdy), 32'd0);
      check("bp_valid_held", 32'(obs_valid), 32'd1);
      check("bp_sum_stable", 32'(obs_sum), 32'd8);
      check("bp_count_stable", 32'(obs_cnt), 32'd2);
    end
    din_valid = 1'b0;
    handshake();
    push(16'd8, 9'd2, 1'b0);
    send(8'd4, 1'b0);
    send(8'd4, 1'b1);
    collect();
    handshake();

    // Reset mid-packet discards partial state
    send(8'd7, 1'b0);
    send(8'd9, 1'b0);
    rst = 1'b1;
    tick();
    check("midrst_sum", 32'(obs_sum), 32'd0);
    check("midrst_count", 32'(obs_cnt), 32'd0);
    check("midrst_valid", 32'(obs_valid), 32'd0);
    check("midrst_ready", 32'(obs_rdy), 32'd0);
    rst = 1'b0;
    #1;
    push(16'd1, 9'd1, 1'b0);
    send(8'd1, 1'b1);
    collect();
    handshake();

    // Signed operands
    sel = 1;
    #1;
    push(16'h0002, 9'd3, 1'b0);
    send(8'hFF, 1'b0);
    send(8'hFE, 1'b0);
    send(8'h05, 1'b1);
    collect();
    handshake();

    // MAX_WORDS=4: over-long packet wraps, count saturates, ovf set
    sel = 2;
    #1;
    push(16'd251, 9'd4, 1'b1);
    for (int i = 0; i < 5; i++) send(8'hFF, i == 4);
    collect();
    handshake();
    push(16'd1, 9'd1, 1'b0);
    send(8'd1, 1'b1);
    collect();
    handshake();

    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
